// File: rtl/morra_match_scheduler.sv
// rtl/morra_match_scheduler.sv - match sequencer in front of the MorraCinese core
// Collects both moves, drives the core one round at a time and keeps the match score.
module morra_match_scheduler #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       cfg_extra,
    input  logic             abort,
    input  logic             p1_valid,
    input  logic [1:0]       p1_move,
    output logic             p1_ready,
    input  logic             p2_valid,
    input  logic [1:0]       p2_move,
    output logic             p2_ready,
    output logic [1:0]       core_primo,
    output logic [1:0]       core_secondo,
    output logic             core_inizia,
    input  logic [1:0]       core_manche,
    input  logic [1:0]       core_partita,
    output logic             round_valid,
    output logic [1:0]       round_result,
    output logic [CNT_W-1:0] p1_score,
    output logic [CNT_W-1:0] p2_score,
    output logic [CNT_W-1:0] round_cnt,
    output logic             match_done,
    output logic [1:0]       match_result,
    output logic             overrun
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_CONFIG, S_COLLECT, S_ISSUE, S_WAIT, S_RESULT, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       extra_q, extra_d;
    logic [1:0]       m1_q, m1_d, m2_q, m2_d;
    logic             have1_q, have1_d, have2_q, have2_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0] p1_score_q, p1_score_d, p2_score_q, p2_score_d;
    logic [CNT_W-1:0] round_cnt_q, round_cnt_d, rc_next, round_limit;
    logic [1:0]       round_result_q, round_result_d;
    logic [1:0]       match_result_q, match_result_d;
    logic             overrun_q, overrun_d;
    logic             timeout_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != CNT_MAX)) begin
            return v + CNT_W'(1);
        end
        return v;
    endfunction

    assign round_limit = CNT_W'(4) + CNT_W'(extra_q);

    always_comb begin
        state_d        = state_q;
        extra_d        = extra_q;
        m1_d           = m1_q;
        m2_d           = m2_q;
        have1_d        = have1_q;
        have2_d        = have2_q;
        to_cnt_d       = to_cnt_q;
        p1_score_d     = p1_score_q;
        p2_score_d     = p2_score_q;
        round_cnt_d    = round_cnt_q;
        rc_next        = round_cnt_q;
        round_result_d = round_result_q;
        match_result_d = match_result_q;
        overrun_d      = overrun_q;
        core_primo     = 2'b00;
        core_secondo   = 2'b00;
        core_inizia    = 1'b0;
        round_valid    = 1'b0;

        // The missing player loses its ready in the cycle its move gets forced.
        timeout_hit = (state_q == S_COLLECT) && (have1_q ^ have2_q)
                      && (to_cnt_q == TO_W'(TIMEOUT));
        p1_ready = (state_q == S_COLLECT) && !have1_q && !timeout_hit;
        p2_ready = (state_q == S_COLLECT) && !have2_q && !timeout_hit;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    extra_d     = cfg_extra;
                    p1_score_d  = '0;
                    p2_score_d  = '0;
                    round_cnt_d = '0;
                    overrun_d   = 1'b0;
                    state_d     = S_CONFIG;
                end
            end
            S_CONFIG: begin
                core_inizia  = 1'b1;
                core_primo   = extra_q[3:2];
                core_secondo = extra_q[1:0];
                have1_d      = 1'b0;
                have2_d      = 1'b0;
                to_cnt_d     = '0;
                state_d      = S_COLLECT;
            end
            S_COLLECT: begin
                if (p1_valid && p1_ready) begin
                    m1_d    = p1_move;
                    have1_d = 1'b1;
                end
                if (p2_valid && p2_ready) begin
                    m2_d    = p2_move;
                    have2_d = 1'b1;
                end
                if (timeout_hit) begin
                    if (!have1_q) begin
                        m1_d    = 2'b00;
                        have1_d = 1'b1;
                    end
                    if (!have2_q) begin
                        m2_d    = 2'b00;
                        have2_d = 1'b1;
                    end
                end else if (have1_q ^ have2_q) begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
                if (have1_d && have2_d) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                core_primo   = m1_q;
                core_secondo = m2_q;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                state_d = S_RESULT;
            end
            S_RESULT: begin
                round_valid    = 1'b1;
                round_result_d = core_manche;
                p1_score_d     = sat_inc(p1_score_q, core_manche == 2'b01);
                p2_score_d     = sat_inc(p2_score_q, core_manche == 2'b10);
                rc_next        = sat_inc(round_cnt_q, core_manche != 2'b00);
                round_cnt_d    = rc_next;
                if ((rc_next > round_limit) && (core_partita == 2'b00)) begin
                    overrun_d = 1'b1;
                end
                have1_d  = 1'b0;
                have2_d  = 1'b0;
                to_cnt_d = '0;
                if (core_partita != 2'b00) begin
                    match_result_d = core_partita;
                    state_d        = S_DONE;
                end else begin
                    state_d = S_COLLECT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d        = S_IDLE;
            p1_score_d     = '0;
            p2_score_d     = '0;
            round_cnt_d    = '0;
            overrun_d      = 1'b0;
            match_result_d = 2'b00;
            round_result_d = round_result_q;
            have1_d        = 1'b0;
            have2_d        = 1'b0;
            to_cnt_d       = '0;
            core_primo     = 2'b00;
            core_secondo   = 2'b00;
            core_inizia    = 1'b0;
            round_valid    = 1'b0;
        end

        round_result = round_valid ? core_manche : round_result_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            extra_q        <= '0;
            m1_q           <= '0;
            m2_q           <= '0;
            have1_q        <= 1'b0;
            have2_q        <= 1'b0;
            to_cnt_q       <= '0;
            p1_score_q     <= '0;
            p2_score_q     <= '0;
            round_cnt_q    <= '0;
            round_result_q <= '0;
            match_result_q <= '0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            extra_q        <= extra_d;
            m1_q           <= m1_d;
            m2_q           <= m2_d;
            have1_q        <= have1_d;
            have2_q        <= have2_d;
            to_cnt_q       <= to_cnt_d;
            p1_score_q     <= p1_score_d;
            p2_score_q     <= p2_score_d;
            round_cnt_q    <= round_cnt_d;
            round_result_q <= round_result_d;
            match_result_q <= match_result_d;
            overrun_q      <= overrun_d;
        end
    end

    assign p1_score     = p1_score_q;
    assign p2_score     = p2_score_q;
    assign round_cnt    = round_cnt_q;
    assign match_done   = (state_q == S_DONE);
    assign match_result = match_result_q;
    assign overrun      = overrun_q;

endmodule

// File: doc/morra_match_scheduler.md
Name: morra_match_scheduler

Overview:
Sequencing controller in front of the MorraCinese game core. It collects one move per player through independent valid/ready handshakes and configures the core at match start (INIZIA plus round count). It then presents each move pair to the core for exactly one cycle, samples the registered MANCHE/PARTITA results and keeps per-player score and round counters. It also enforces a per-round move timeout and reports the match outcome to the host.

Parameters:
TIMEOUT, 16, cycles allowed in COLLECT after the first move is captured before the missing move is forced to 2'b00 (invalid).
CNT_W, 5, width of round and score counters; must hold 19.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  host pulse: begin a new match (accepted in IDLE or DONE)
cfg_extra  in  4  match length minus 4 (max rounds = 4 + cfg_extra), latched on start
abort  in  1  return to IDLE from any state
p1_valid / p1_move / p1_ready  in/in/out  1/2/1  player 1 move handshake; 01 sasso, 10 carta, 11 forbice, 00 invalid
p2_valid / p2_move / p2_ready  in/in/out  1/2/1  player 2, same encoding
core_primo  out  2  to core PRIMO
core_secondo  out  2  to core SECONDO
core_inizia  out  1  to core INIZIA
core_manche  in  2  from core MANCHE: 00 invalid, 01 P1, 10 P2, 11 draw
core_partita  in  2  from core PARTITA: 00 running, 01 P1, 10 P2, 11 draw
round_valid  out  1  one-cycle pulse: core_manche sampled
round_result  out  2  sampled core_manche, held until next round_valid
p1_score / p2_score  out  CNT_W  rounds won
round_cnt  out  CNT_W  valid rounds played (manche != 00)
match_done  out  1  high in DONE
match_result  out  2  sampled core_partita, held in DONE
overrun  out  1  sticky; round_cnt exceeded 4+cfg_extra with partita still 00

Behaviour:
- Reset (rst_n=0 at an edge) takes priority over everything: state IDLE; all outputs 0, including core_* = 0, ready = 0 and all counters = 0. Takes effect mid-match with no core handshake; the next match's INIZIA reconfigures the core.
- abort (lower priority than reset): next state IDLE; scores, round_cnt, overrun and match_result are cleared; core_* = 0.
- States: IDLE, CONFIG, COLLECT, ISSUE, WAIT, RESULT, DONE.
- IDLE/DONE + start: latch cfg_extra, clear counters and overrun, go to CONFIG. In DONE without start, hold all results.
- CONFIG (1 cycle): core_inizia=1, core_primo=cfg_extra[3:2], core_secondo=cfg_extra[1:0]. Next state COLLECT.
- COLLECT:
  - Each pN_ready=1 until that player's move is captured (pN_valid & pN_ready at an edge), then 0. A player's second move in the same round is not accepted.
  - Both moves captured on the same edge is legal.
  - The timeout counter starts the cycle after the first capture. When it reaches TIMEOUT with one move still missing, that move is forced to 00.
  - Go to ISSUE once both moves are held.
- ISSUE (1 cycle): core_inizia=0, core_primo/core_secondo = captured moves. In every other state core_primo/core_secondo/core_inizia = 0.
- WAIT (1 cycle): core outputs become valid because the core registers on the ISSUE edge.
- RESULT (1 cycle):
  - Sample core_manche and core_partita; round_valid=1; round_result=core_manche.
  - 01 increments p1_score, 10 increments p2_score. 01/10/11 increment round_cnt; 00 increments nothing.
  - If round_cnt after increment > 4+cfg_extra and partita==00, set overrun.
  - partita != 00: go to DONE with match_result=partita. Otherwise return to COLLECT with captured moves and the timeout counter cleared.
- Counters saturate at 2^CNT_W-1, no wrap.
- Round latency: both moves captured at edge N gives round_valid high in cycle N+3.

Test Plan:
- Reset during ISSUE with rst_n=0 for 1 cycle -> next cycle state IDLE, core_* = 0, p1_ready = p2_ready = 0, scores 0.
- start with cfg_extra=4'b0000 -> one cycle with core_inizia=1, core_primo=00, core_secondo=00, then p1_ready = p2_ready = 1.
- P1 11 and P2 10 captured on the same edge; core returns manche=01, partita=00 -> round_valid 3 cycles later, round_result=01, p1_score=1, round_cnt=1, back to COLLECT.
- P1 01 captured, P2 silent for TIMEOUT=16 cycles -> ISSUE drives core_primo=01, core_secondo=00; core manche=00 -> round_result=00, round_cnt unchanged.
- Core returns partita=10 after 3 rounds -> match_done=1, match_result=10, held for 10 idle cycles. A following start clears scores and enters CONFIG.
- cfg_extra=0, core returns manche=11 with partita=00 for 5 rounds -> overrun=1 after round 5; abort in the next COLLECT -> IDLE with overrun=0.
